// File: rtl/fetch_branch_unit.sv
// rtl/fetch_branch_unit.sv - PC, branch resolution and instruction fetch stage
// Optional feature macro: FETCH_STATS_EN enables the taken/squash statistics counters.
module fetch_branch_unit #(
  parameter int                ADDR_W   = 32,
  parameter int                DATA_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              loadPC,
  input  logic [2:0]        BRANCH,
  input  logic [ADDR_W-1:0] imm,
  input  logic [DATA_W-1:0] rs_val,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [DATA_W-1:0] imem_rdata,
  input  logic              imem_valid,
  output logic [ADDR_W-1:0] pc,
  output logic [DATA_W-1:0] ir,
  output logic [3:0]        op_code,
  output logic              ir_valid,
  output logic              br_taken,
  output logic [15:0]       taken_cnt,
  output logic [15:0]       squash_cnt
);

  localparam logic [2:0] BR_SEQ = 3'b000;
  localparam logic [2:0] BR_BR  = 3'b001;
  localparam logic [2:0] BR_BMI = 3'b010;
  localparam logic [2:0] BR_BPL = 3'b011;
  localparam logic [2:0] BR_BZ  = 3'b100;
  localparam logic [2:0] BR_JR  = 3'b101;

  localparam logic [ADDR_W-1:0] PC_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
  // Reset IR decodes as NOP so control sees a harmless opcode before the first fetch.
  localparam logic [DATA_W-1:0] IR_NOP  = {4'hE, {(DATA_W-4){1'b0}}};

  typedef enum logic [1:0] {
    S_REQ,
    S_HOLD,
    S_DRAIN
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] seq_pc;
  logic [ADDR_W-1:0] tgt_pc;
  logic [ADDR_W-1:0] next_pc;
  logic              take;
  logic              rs_neg;
  logic              rs_zero;

  assign imem_addr = pc;
  assign op_code   = ir[DATA_W-1 -: 4];

  // Resolve the branch selector into the next PC; take marks any non-sequential path.
  always_comb begin
    seq_pc  = pc + PC_ONE;
    tgt_pc  = pc + imm;
    rs_neg  = rs_val[DATA_W-1];
    rs_zero = (rs_val == '0);
    take    = 1'b0;
    next_pc = seq_pc;
    case (BRANCH)
      BR_SEQ: take = 1'b0;
      BR_BR:  take = 1'b1;
      BR_BMI: take = rs_neg;
      BR_BPL: take = ~rs_neg;
      BR_BZ:  take = rs_zero;
      default: take = 1'b0;
    endcase
    if (BRANCH == BR_JR) begin
      take    = 1'b1;
      next_pc = rs_val[ADDR_W-1:0];
    end else if (take) begin
      next_pc = tgt_pc;
    end
  end

  // Fetch FSM with registered request, IR and branch-taken pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_REQ;
      pc       <= RESET_PC;
      ir       <= IR_NOP;
      ir_valid <= 1'b0;
      imem_req <= 1'b0;
      br_taken <= 1'b0;
    end else begin
      br_taken <= 1'b0;
      if (loadPC) begin
        pc       <= next_pc;
        br_taken <= take;
      end
      case (state)
        S_REQ: begin
          if (!imem_req) begin
            // First cycle after reset: any imem_valid here belongs to an abandoned fetch.
            imem_req <= 1'b1;
          end else if (loadPC) begin
            if (imem_valid) begin
              // Response and retarget together: drop the word, re-request at the new pc.
              state <= S_REQ;
            end else begin
              // Outstanding request must still be answered; swallow it in DRAIN.
              imem_req <= 1'b0;
              state    <= S_DRAIN;
            end
          end else if (imem_valid) begin
            ir       <= imem_rdata;
            ir_valid <= 1'b1;
            imem_req <= 1'b0;
            state    <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (loadPC) begin
            ir_valid <= 1'b0;
            imem_req <= 1'b1;
            state    <= S_REQ;
          end
        end
        S_DRAIN: begin
          if (imem_valid) begin
            imem_req <= 1'b1;
            state    <= S_REQ;
          end
        end
        default: begin
          imem_req <= 1'b0;
          state    <= S_REQ;
        end
      endcase
    end
  end

`ifdef FETCH_STATS_EN
  logic taken_evt;
  logic squash_evt;

  assign taken_evt  = loadPC & take;
  assign squash_evt = loadPC & imem_req & (state == S_REQ);

  // Saturating statistics counters for taken branches and squashed fetches.
  always_ff @(posedge clk) begin
    if (reset) begin
      taken_cnt  <= 16'h0000;
      squash_cnt <= 16'h0000;
    end else begin
      if (taken_evt && (taken_cnt != 16'hFFFF)) begin
        taken_cnt <= taken_cnt + 16'h0001;
      end
      if (squash_evt && (squash_cnt != 16'hFFFF)) begin
        squash_cnt <= squash_cnt + 16'h0001;
      end
    end
  end
`else
  assign taken_cnt  = 16'h0000;
  assign squash_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_fetch_branch_unit.sv
// tb/tb_fetch_branch_unit.sv - scoreboard testbench for fetch_branch_unit
module tb_fetch_branch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        loadPC;
  logic [2:0]  BRANCH;
  logic [31:0] imm;
  logic [31:0] rs_val;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_valid;
  logic [31:0] pc;
  logic [31:0] ir;
  logic [3:0]  op_code;
  logic        ir_valid;
  logic        br_taken;
  logic [15:0] taken_cnt;
  logic [15:0] squash_cnt;

`ifdef FETCH_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  fetch_branch_unit #(.ADDR_W(32), .DATA_W(32), .RESET_PC(32'h0)) dut (
    .clk(clk), .reset(reset), .loadPC(loadPC), .BRANCH(BRANCH), .imm(imm), .rs_val(rs_val),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata), .imem_valid(imem_valid),
    .pc(pc), .ir(ir), .op_code(op_code), .ir_valid(ir_valid), .br_taken(br_taken),
    .taken_cnt(taken_cnt), .squash_cnt(squash_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic        taken;
  } commit_t;

  commit_t     commit_q[$];
  logic [31:0] req_q[$];
  logic [31:0] ir_q[$];
  int checks = 0;
  int errors = 0;
  int exp_taken = 0;
  int exp_squash = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic unexpected(input string name, input logic [31:0] got);
    checks++;
    errors++;
    $display("FAIL %s: got unexpected event value %0h expected none", name, got);
  endtask

  // Monitor: observes commits, new requests and fetch completions.
  logic        load_seen = 1'b0;
  logic        prev_req  = 1'b0;
  logic [31:0] prev_addr = 32'h0;
  logic        prev_irv  = 1'b0;
  commit_t     mc;
  logic [31:0] mv;

  always @(posedge clk) load_seen <= loadPC && !reset;

  always @(negedge clk) begin
    if (load_seen) begin
      if (commit_q.size() == 0) unexpected("commit", pc);
      else begin
        mc = commit_q.pop_front();
        check("commit_pc", pc, mc.pc);
        check("commit_br_taken", {31'b0, br_taken}, {31'b0, mc.taken});
      end
    end
    if (imem_req && (!prev_req || imem_addr != prev_addr)) begin
      if (req_q.size() == 0) unexpected("imem_req", imem_addr);
      else begin
        mv = req_q.pop_front();
        check("imem_addr", imem_addr, mv);
      end
    end
    if (ir_valid && !prev_irv) begin
      if (ir_q.size() == 0) unexpected("ir_valid", ir);
      else begin
        mv = ir_q.pop_front();
        check("ir", ir, mv);
        check("op_code", {28'b0, op_code}, {28'b0, mv[31:28]});
      end
    end
    prev_req  = imem_req;
    prev_addr = imem_addr;
    prev_irv  = ir_valid;
  end

  task automatic do_load(input logic [2:0] br, input logic [31:0] imm_v, input logic [31:0] rs_v,
                         input logic [31:0] exp_pc, input bit exp_t, input bit push_req);
    commit_t c;
    c.pc = exp_pc;
    c.taken = exp_t;
    commit_q.push_back(c);
    if (push_req) req_q.push_back(exp_pc);
    if (exp_t) exp_taken++;
    BRANCH = br;
    imm    = imm_v;
    rs_val = rs_v;
    loadPC = 1'b1;
    @(negedge clk);
    loadPC = 1'b0;
  endtask

  task automatic do_fetch(input logic [31:0] data, input int delay);
    int n;
    ir_q.push_back(data);
    n = 0;
    while (!imem_req && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!imem_req) begin
      unexpected("fetch_req_timeout", pc);
      return;
    end
    repeat (delay) @(negedge clk);
    imem_valid = 1'b1;
    imem_rdata = data;
    @(negedge clk);
    imem_valid = 1'b0;
    n = 0;
    while (!ir_valid && n < 5) begin
      @(negedge clk);
      n++;
    end
    if (!ir_valid) unexpected("ir_valid_timeout", ir);
  endtask

  task automatic check_reset_state();
    check("rst_pc", pc, 32'h0);
    check("rst_ir_valid", {31'b0, ir_valid}, 32'h0);
    check("rst_op_code", {28'b0, op_code}, 32'hE);
    check("rst_imem_req", {31'b0, imem_req}, 32'h0);
    check("rst_br_taken", {31'b0, br_taken}, 32'h0);
    check("rst_taken_cnt", {16'b0, taken_cnt}, 32'h0);
    check("rst_squash_cnt", {16'b0, squash_cnt}, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; loadPC = 1'b0; BRANCH = 3'b000; imm = 32'h0; rs_val = 32'h0;
    imem_valid = 1'b0; imem_rdata = 32'h0;
    repeat (2) @(negedge clk);
    check_reset_state();
    req_q.push_back(32'h0);
    reset = 1'b0;

    do_fetch(32'h1000_0005, 2);
    repeat (3) @(negedge clk);
    check("hold_imem_req", {31'b0, imem_req}, 32'h0);
    check("hold_ir_valid", {31'b0, ir_valid}, 32'h1);
    check("hold_ir", ir, 32'h1000_0005);

    do_load(3'b101, 32'h0,         32'h10,        32'h10,        1'b1, 1'b1); do_fetch(32'h2000_0010, 1);
    do_load(3'b001, 32'hFFFF_FFFC, 32'h0,         32'h0C,        1'b1, 1'b1); do_fetch(32'h3000_000C, 0);
    do_load(3'b101, 32'h0,         32'h20,        32'h20,        1'b1, 1'b1); do_fetch(32'h4000_0020, 3);
    do_load(3'b100, 32'h8,         32'h5,         32'h21,        1'b0, 1'b1); do_fetch(32'h5000_0021, 1);
    do_load(3'b101, 32'h0,         32'h20,        32'h20,        1'b1, 1'b1); do_fetch(32'h6000_0020, 1);
    do_load(3'b100, 32'h8,         32'h0,         32'h28,        1'b1, 1'b1); do_fetch(32'h7000_0028, 2);
    do_load(3'b010, 32'h10,        32'h8000_0000, 32'h38,        1'b1, 1'b1); do_fetch(32'h8000_0038, 1);
    do_load(3'b011, 32'h10,        32'h8000_0000, 32'h39,        1'b0, 1'b1); do_fetch(32'h9000_0039, 1);
    do_load(3'b101, 32'h0,         32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b1); do_fetch(32'hA000_FFFF, 1);
    do_load(3'b000, 32'h0,         32'h0,         32'h0,         1'b0, 1'b1); do_fetch(32'hB000_0000, 0);
    do_load(3'b101, 32'h0,         32'h40,        32'h40,        1'b1, 1'b1); do_fetch(32'hC000_0040, 1);
    do_load(3'b111, 32'd100,       32'h0,         32'h41,        1'b0, 1'b1); do_fetch(32'hD000_0041, 1);
    check("taken_cnt_branches", {16'b0, taken_cnt}, STATS ? exp_taken : 0);

    // Squash with a late orphaned response.
    do_load(3'b101, 32'h0, 32'h80, 32'h80, 1'b1, 1'b1);
    exp_squash++;
    do_load(3'b000, 32'h0, 32'h0, 32'h81, 1'b0, 1'b0);
    check("drain_imem_req", {31'b0, imem_req}, 32'h0);
    repeat (2) @(negedge clk);
    req_q.push_back(32'h81);
    imem_valid = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    imem_valid = 1'b0;
    do_fetch(32'h2000_0001, 1);
    check("squash_cnt_drain", {16'b0, squash_cnt}, STATS ? exp_squash : 0);

    // Retarget in the same cycle as the response.
    do_load(3'b101, 32'h0, 32'h100, 32'h100, 1'b1, 1'b1);
    exp_squash++;
    commit_q.push_back('{32'h101, 1'b0});
    req_q.push_back(32'h101);
    BRANCH = 3'b000;
    loadPC = 1'b1;
    imem_valid = 1'b1;
    imem_rdata = 32'h0BAD_0001;
    @(negedge clk);
    loadPC = 1'b0;
    imem_valid = 1'b0;
    do_fetch(32'h3000_0002, 2);
    check("squash_cnt_same", {16'b0, squash_cnt}, STATS ? exp_squash : 0);
    check("taken_cnt_total", {16'b0, taken_cnt}, STATS ? exp_taken : 0);

    // Reset while a request is outstanding, then a late response.
    do_load(3'b101, 32'h0, 32'h200, 32'h200, 1'b1, 1'b1);
    reset = 1'b1;
    @(negedge clk);
    check_reset_state();
    req_q.push_back(32'h0);
    reset = 1'b0;
    imem_valid = 1'b1;
    imem_rdata = 32'h0BAD_0BAD;
    @(negedge clk);
    imem_valid = 1'b0;
    do_fetch(32'h4000_0004, 1);
    check("post_reset_pc", pc, 32'h0);

    repeat (3) @(negedge clk);
    check("commit_q_empty", commit_q.size(), 32'h0);
    check("req_q_empty", req_q.size(), 32'h0);
    check("ir_q_empty", ir_q.size(), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
